dm_bus_arbiter: RTL and testbench



---
 rtl/dm_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_dm_bus_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_bus_arbiter.sv
// Round-robin arbiter sharing the debug module's hart-side bus slave
// between NUM_HART requesters, with a watchdog on unaccepted requests.
module dm_bus_arbiter #(
    parameter int NUM_HART = 2,
    parameter int TIMEOUT  = 64,
    localparam int OW = (NUM_HART > 1) ? $clog2(NUM_HART) : 1,
    localparam int WW = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_HART-1:0]      hart_valid,
    input  logic [NUM_HART-1:0]      hart_write,
    input  logic [NUM_HART*20-1:0]   hart_addr,
    input  logic [NUM_HART*32-1:0]   hart_wdata,
    output logic [NUM_HART-1:0]      hart_ready,
    output logic                     hart_err,
    output logic [31:0]              hart_rdata,
    output logic                     bus_valid,
    output logic                     bus_write,
    output logic [19:0]              bus_addr,
    output logic [31:0]              bus_wdata,
    input  logic                     bus_ready,
    input  logic [31:0]              bus_rdata,
    output logic [OW-1:0]            owner
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]    r_state;
    logic [OW-1:0] r_rr_ptr;
    logic [OW-1:0] r_owner;
    logic [WW-1:0] r_wd_cnt;
    logic          r_write;
    logic [19:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_result;
    logic          r_err;

    logic          w_any;
    logic [OW-1:0] w_pick;
    logic [OW-1:0] w_rr_next;
    logic [WW-1:0] w_wd_next;
    logic          w_timeout;

    // First requesting hart at or after the rotation pointer, wrapping.
    always_comb begin
        int k;
        w_any  = 1'b0;
        w_pick = '0;
        k      = 0;
        for (int i = 0; i < NUM_HART; i++) begin
            k = int'(r_rr_ptr) + i;
            if (k >= NUM_HART) begin
                k = k - NUM_HART;
            end
            if (!w_any && hart_valid[k]) begin
                w_any  = 1'b1;
                w_pick = OW'(k);
            end
        end
    end

    assign w_rr_next = (r_owner == OW'(NUM_HART - 1)) ? '0 : r_owner + 1'b1;
    assign w_wd_next = (r_wd_cnt == '1) ? r_wd_cnt : r_wd_cnt + 1'b1;
    assign w_timeout = (TIMEOUT != 0) && (r_wd_cnt == WW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_wd_cnt <= '0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner  <= w_pick;
                        r_write  <= hart_write[w_pick];
                        r_addr   <= hart_addr[int'(w_pick)*20 +: 20];
                        r_wdata  <= hart_wdata[int'(w_pick)*32 +: 32];
                        r_wd_cnt <= '0;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wd_cnt <= w_wd_next;
                    // A handshake in the final watchdog cycle still wins.
                    if (bus_ready) begin
                        r_result <= r_write ? 32'd0 : bus_rdata;
                        r_err    <= 1'b0;
                        r_state  <= S_RESP;
                    end else if (w_timeout) begin
                        r_result <= 32'd0;
                        r_err    <= 1'b1;
                        r_state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_rr_ptr <= w_rr_next;
                    r_wd_cnt <= '0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        hart_ready = '0;
        if (r_state == S_RESP) begin
            hart_ready[r_owner] = 1'b1;
        end
    end

    assign hart_err   = (r_state == S_RESP) && r_err;
    assign hart_rdata = (r_state == S_RESP) ? r_result : 32'd0;
    assign bus_valid  = (r_state == S_ISSUE);
    assign bus_write  = r_write;
    assign bus_addr   = r_addr;
    assign bus_wdata  = r_wdata;
    assign owner      = r_owner;

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Bench for dm_bus_arbiter: transaction-level model of rotation,
// watchdog and slave latency, with directed and random steps.
module tb_dm_bus_arbiter;

    localparam int N = 3;
    localparam int T = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  hart_valid;
    logic [N-1:0]  hart_write;
    logic [N*20-1:0] hart_addr;
    logic [N*32-1:0] hart_wdata;
    logic [N-1:0]  hart_ready;
    logic          hart_err;
    logic [31:0]   hart_rdata;
    logic          bus_valid;
    logic          bus_write;
    logic [19:0]   bus_addr;
    logic [31:0]   bus_wdata;
    logic          bus_ready;
    logic [31:0]   bus_rdata;
    logic [1:0]    owner;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Slave: accepts on the D-th cycle of bus_valid; D=0 never accepts.
    int D = 2;
    int vcnt = 0;

    // Model state
    int          rr = 0;
    bit          m_pend [N];
    bit          m_write[N];
    logic [19:0] m_addr [N];
    logic [31:0] m_wdata[N];

    dm_bus_arbiter #(.NUM_HART(N), .TIMEOUT(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .hart_valid (hart_valid),
        .hart_write (hart_write),
        .hart_addr  (hart_addr),
        .hart_wdata (hart_wdata),
        .hart_ready (hart_ready),
        .hart_err   (hart_err),
        .hart_rdata (hart_rdata),
        .bus_valid  (bus_valid),
        .bus_write  (bus_write),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ready  (bus_ready),
        .bus_rdata  (bus_rdata),
        .owner      (owner)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] slave_data(input logic [19:0] a);
        if (a == 20'h00400) return 32'h12345678;
        return {a[11:0], 20'h0} ^ {12'hA5C, a};
    endfunction

    always @(posedge clk) vcnt <= bus_valid ? vcnt + 1 : 0;

    assign bus_ready = bus_valid && (D != 0) && (vcnt == D - 1);
    assign bus_rdata = bus_ready ? slave_data(bus_addr) : 32'hDEADBEEF;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s txn=%0d: observed %0h expected %0h",
                   tag, txn, obs, exp);
        end
    endtask

    function automatic int rr_pick();
        for (int i = 0; i < N; i++) begin
            if (m_pend[(rr + i) % N]) return (rr + i) % N;
        end
        return -1;
    endfunction

    task automatic raise(input int h, input bit w,
                         input logic [19:0] a, input logic [31:0] d);
        m_pend[h]  = 1'b1;
        m_write[h] = w;
        m_addr[h]  = a;
        m_wdata[h] = d;
        hart_valid[h] = 1'b1;
        hart_write[h] = w;
        hart_addr[h*20 +: 20]  = a;
        hart_wdata[h*32 +: 32] = d;
    endtask

    task automatic drop(input int h);
        m_pend[h]     = 1'b0;
        hart_valid[h] = 1'b0;
    endtask

    // One transaction from grant to completion, checked against the model.
    task automatic serve(input bit rel);
        int h, n, vc, exp_vc;
        bit err_e, stable;
        logic [31:0] rd_e;
        logic [52:0] fld;
        txn++;
        h = rr_pick();
        n = 0;
        while (!bus_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("grant_latency", 64'(n), 64'd1);
        chk("owner", 64'(owner), 64'(h));
        fld = {m_write[h], m_addr[h], m_wdata[h]};
        chk("bus_fields", 64'({bus_write, bus_addr, bus_wdata}), 64'(fld));
        stable = 1'b1;
        vc = 0;
        while (bus_valid && vc < 40) begin
            if ({bus_write, bus_addr, bus_wdata} !== fld) stable = 1'b0;
            if (hart_ready !== '0) stable = 1'b0;
            vc++;
            @(posedge clk); #1;
        end
        err_e  = (D == 0) || (D > T);
        exp_vc = err_e ? T : D;
        rd_e   = (err_e || m_write[h]) ? 32'd0 : slave_data(m_addr[h]);
        chk("valid_cycles", 64'(vc), 64'(exp_vc));
        chk("issue_stable", 64'(stable), 64'd1);
        chk("ready_onehot", 64'(hart_ready), 64'(1 << h));
        chk("err", 64'(hart_err), 64'(err_e));
        chk("rdata", 64'(hart_rdata), 64'(rd_e));
        rr = (h + 1) % N;
        if (rel) drop(h);
        @(posedge clk); #1;
        chk("idle_ready", 64'({hart_ready, hart_rdata}), 64'd0);
    endtask

    initial begin
        int n;
        hart_valid = '0;
        hart_write = '0;
        hart_addr  = '0;
        hart_wdata = '0;
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;

        reset = 1'b1;
        #1;
        chk("reset_outs", 64'({bus_valid, bus_write, bus_addr, bus_wdata,
                               hart_ready, hart_err}), 64'd0);
        chk("reset_rdata_owner", 64'({hart_rdata, owner}), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Single read, DM slave timing
        D = 2;
        raise(0, 1'b0, 20'h00400, 32'h0);
        serve(1'b1);

        // Write from hart 1
        raise(1, 1'b1, 20'h00408, 32'hCAFEF00D);
        serve(1'b1);

        // Requests held through reset: rotation 0,1,2,0,1,2 then 0,2,0,2
        reset = 1'b1;
        rr = 0;
        for (int i = 0; i < N; i++)
            raise(i, 1'b0, 20'h00100 + 20'(i * 4), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) serve(1'b0);
        drop(1);
        for (int i = 0; i < 4; i++) serve(1'b0);
        for (int i = 0; i < N; i++) drop(i);
        @(posedge clk); #1;

        // Watchdog: never accepted, accepted on last cycle, one too late
        D = 0;
        raise(2, 1'b0, 20'h00380, 32'h0);
        serve(1'b1);
        D = 8;
        raise(0, 1'b0, 20'h00384, 32'h0);
        serve(1'b1);
        D = 9;
        raise(1, 1'b1, 20'h00388, 32'h11112222);
        serve(1'b1);

        // Reset mid-ISSUE: hart 1 done leaves rotation at 2
        D = 2;
        raise(1, 1'b0, 20'h00404, 32'h0);
        serve(1'b1);
        D = 0;
        raise(2, 1'b0, 20'h0040C, 32'h0);
        n = 0;
        while (!bus_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("rst_issue_seen", 64'(bus_valid), 64'd1);
        @(posedge clk); #1;
        #3;
        reset = 1'b1;
        #1;
        chk("rst_async_valid", 64'(bus_valid), 64'd0);
        chk("rst_async_ready", 64'({hart_ready, owner}), 64'd0);
        raise(1, 1'b0, 20'h00410, 32'h0);
        rr = 0;
        @(posedge clk); #1;
        chk("rst_no_ready", 64'(hart_ready), 64'd0);
        reset = 1'b0;
        D = 2;
        serve(1'b1);
        serve(1'b1);

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            for (int h = 0; h < N; h++) begin
                if (!m_pend[h] && $urandom_range(0, 1) == 1)
                    raise(h, 1'($urandom_range(0, 1)),
                          20'($urandom), $urandom);
            end
            if (rr_pick() < 0) begin
                n = $urandom_range(0, N - 1);
                raise(n, 1'($urandom_range(0, 1)), 20'($urandom), $urandom);
            end
            D = $urandom_range(0, 10);
            serve(1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
